// File: rtl/axi_s2mm_ring.sv
// Stream-to-AXI3 ring-buffer writer: FIFO-buffered samples go out as fixed-length INCR bursts.
// Optional build macro AXI_S2MM_BSWAP_EN byte-reverses each 32-bit lane of AXI_wdata.
//   state | meaning
//   IDLE  | waiting for BLEN words in the FIFO; applies a pending sync
//   AW    | presenting burst address until awready
//   W     | streaming BLEN beats out of the FIFO
//   B     | waiting for the write response
module axi_s2mm_ring #(
    parameter int          DW      = 32,
    parameter int          BLEN    = 16,
    parameter int          FIFO_AW = 5,
    parameter logic [5:0]  AXI_ID  = 6'h3F
) (
    input  logic                AXI_clk,
    input  logic                rst,
    input  logic                sync,
    input  logic [DW-1:0]       Sin,
    input  logic                Ien,
    input  logic [31:0]         base,
    input  logic [17:0]         size,
    output logic [17:0]         acnt,
    output logic [31:0]         bcnt,
    output logic [15:0]         ovf_cnt,
    output logic [15:0]         err_cnt,
    output logic [31:0]         AXI_awaddr,
    output logic                AXI_awvalid,
    input  logic                AXI_awready,
    output logic [5:0]          AXI_awid,
    output logic [3:0]          AXI_awlen,
    output logic [2:0]          AXI_awsize,
    output logic [1:0]          AXI_awburst,
    output logic [1:0]          AXI_awlock,
    output logic [3:0]          AXI_awcache,
    output logic [2:0]          AXI_awprot,
    output logic [3:0]          AXI_awqos,
    output logic [DW-1:0]       AXI_wdata,
    output logic [DW/8-1:0]     AXI_wstrb,
    output logic [5:0]          AXI_wid,
    output logic                AXI_wvalid,
    input  logic                AXI_wready,
    output logic                AXI_wlast,
    input  logic [5:0]          AXI_bid,
    input  logic [1:0]          AXI_bresp,
    input  logic                AXI_bvalid,
    output logic                AXI_bready
);
    localparam int          DEPTH       = 1 << FIFO_AW;
    localparam int          BW          = $clog2(BLEN);
    localparam logic [31:0] BURST_BYTES = 32'(BLEN * DW / 8);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t             state_q;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q, level;
    logic [BW-1:0]      beat_q;
    logic [17:0]        acnt_q, acnt_d;
    logic [18:0]        acnt_inc;
    logic [31:0]        bcnt_q, awaddr_q;
    logic [15:0]        ovf_q, err_q;
    logic               sync_pend_q, sync_eff, full, push, pop, apply;
    logic               awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [DW-1:0]      fifo_out;
    logic               unused_bid;

    assign unused_bid = ^AXI_bid;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign full       = (level == (FIFO_AW+1)'(DEPTH));
    assign sync_eff   = sync | sync_pend_q;
    assign push       = Ien & ~full & ~sync_eff;
    assign pop        = wvalid_q & AXI_wready;
    assign apply      = (state_q == S_IDLE) & sync_eff;
    assign fifo_out   = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    // acnt >= size (e.g. after size shrinks) also wraps to 0
    assign acnt_inc   = {1'b0, acnt_q} + 19'd1;
    assign acnt_d     = (acnt_inc >= {1'b0, size}) ? 18'd0 : acnt_inc[17:0];

    always_ff @(posedge AXI_clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= Sin;
    end

    always_ff @(posedge AXI_clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_q      <= '0;
            acnt_q      <= '0;
            bcnt_q      <= '0;
            ovf_q       <= '0;
            err_q       <= '0;
            sync_pend_q <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            if (Ien && full && !sync_eff && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            if (apply) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                acnt_q      <= '0;
                bcnt_q      <= '0;
                sync_pend_q <= 1'b0;
            end else begin
                if (sync) sync_pend_q <= 1'b1;
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (!sync_eff && size != 18'd0 && level >= (FIFO_AW+1)'(BLEN)) begin
                        awaddr_q  <= base + BURST_BYTES * {14'd0, acnt_q};
                        awvalid_q <= 1'b1;
                        state_q   <= S_AW;
                    end
                end
                S_AW: begin
                    if (AXI_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (AXI_wready) begin
                        beat_q  <= beat_q + 1'b1;
                        wlast_q <= (beat_q == BW'(BLEN-2));
                        if (beat_q == BW'(BLEN-1)) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (AXI_bvalid) begin
                        bready_q <= 1'b0;
                        bcnt_q   <= bcnt_q + 32'd1;
                        acnt_q   <= acnt_d;
                        if (AXI_bresp != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_S2MM_BSWAP_EN
    for (genvar l = 0; l < DW/32; l++) begin : g_bswap
        assign AXI_wdata[32*l +: 32] = {fifo_out[32*l +: 8], fifo_out[32*l+8 +: 8],
                                        fifo_out[32*l+16 +: 8], fifo_out[32*l+24 +: 8]};
    end
`else
    assign AXI_wdata = fifo_out;
`endif

    assign acnt        = acnt_q;
    assign bcnt        = bcnt_q;
    assign ovf_cnt     = ovf_q;
    assign err_cnt     = err_q;
    assign AXI_awaddr  = awaddr_q;
    assign AXI_awvalid = awvalid_q;
    assign AXI_wvalid  = wvalid_q;
    assign AXI_wlast   = wlast_q;
    assign AXI_bready  = bready_q;
    assign AXI_awid    = AXI_ID;
    assign AXI_wid     = AXI_ID;
    assign AXI_awlen   = 4'(BLEN - 1);
    assign AXI_awsize  = 3'($clog2(DW/8));
    assign AXI_awburst = 2'b01;
    assign AXI_awlock  = 2'b00;
    assign AXI_awcache = 4'b0000;
    assign AXI_awprot  = 3'b000;
    assign AXI_awqos   = 4'b0000;
    assign AXI_wstrb   = '1;

endmodule

// File: tb/tb_axi_s2mm_ring.sv
// Randomised bench for axi_s2mm_ring: a queue-based model predicts FIFO contents, burst
// addresses and counters; a negedge monitor compares the DUT against it every cycle.
module tb_axi_s2mm_ring;
    localparam int BLEN  = 16;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst, sync, Ien;
    logic [31:0] Sin, base;
    logic [17:0] size;
    logic [17:0] acnt;
    logic [31:0] bcnt, awaddr, wdata;
    logic [15:0] ovf_cnt, err_cnt;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [5:0]  awid, wid, bid;
    logic [3:0]  awlen, awcache, awqos;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock, bresp;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    axi_s2mm_ring #(.DW(32), .BLEN(BLEN), .FIFO_AW(5), .AXI_ID(6'h3F)) dut (
        .AXI_clk(clk), .rst(rst), .sync(sync), .Sin(Sin), .Ien(Ien), .base(base), .size(size),
        .acnt(acnt), .bcnt(bcnt), .ovf_cnt(ovf_cnt), .err_cnt(err_cnt),
        .AXI_awaddr(awaddr), .AXI_awvalid(awvalid), .AXI_awready(awready),
        .AXI_awid(awid), .AXI_awlen(awlen), .AXI_awsize(awsize), .AXI_awburst(awburst),
        .AXI_awlock(awlock), .AXI_awcache(awcache), .AXI_awprot(awprot), .AXI_awqos(awqos),
        .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wid(wid), .AXI_wvalid(wvalid),
        .AXI_wready(wready), .AXI_wlast(wlast), .AXI_bid(bid), .AXI_bresp(bresp),
        .AXI_bvalid(bvalid), .AXI_bready(bready)
    );

    int checks = 0, failures = 0;
    int aw_mode = 1, w_mode = 1, b_rand = 0, err_at = -1, nb_hs = 0;

    // behavioural model state
    logic [31:0] mq[$];
    logic [31:0] aw_log[$];
    int          m_acnt, m_bcnt, m_ovf, m_err, m_pend, beat, exp_launch;
    int          wlast_cnt, beats_total, started = 0, prev_stall;
    logic [31:0] exp_addr, prev_addr, first_wd;
    bit          first_wd_ok;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] xform(logic [31:0] w);
`ifdef AXI_S2MM_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always @(negedge clk) begin
        int level;
        bit idle, syncing;
        logic [31:0] e;
        if (started != 0) begin
            chk("acnt", 64'(acnt), 64'(m_acnt));
            chk("bcnt", 64'(bcnt), 64'(m_bcnt));
            chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            if (exp_launch >= 0) chk("aw_launch", 64'(awvalid), 64'(exp_launch));
            if (prev_stall != 0) begin
                chk("aw_hold_valid", 64'(awvalid), 64'd1);
                chk("aw_hold_addr", 64'(awaddr), 64'(prev_addr));
            end
        end
        exp_launch = -1;
        if (!rst) begin
            mq.delete();
            m_acnt = 0; m_bcnt = 0; m_ovf = 0; m_err = 0; m_pend = 0;
            prev_stall = 0; beat = 0; started = 1;
        end else if (started != 0) begin
            level   = mq.size();
            idle    = !awvalid && !wvalid && !bready;
            syncing = sync || (m_pend != 0);
            if (awvalid && awready) begin
                chk("awaddr", 64'(awaddr), 64'(exp_addr));
                aw_log.push_back(awaddr);
                beat = 0;
            end
            prev_stall = (awvalid && !awready) ? 1 : 0;
            prev_addr  = awaddr;
            if (wvalid && wready) begin
                if (mq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wdata_underflow actual=beat required=no_beat");
                end else begin
                    e = mq.pop_front();
                    chk("wdata", 64'(wdata), 64'(xform(e)));
                end
                chk("wlast", 64'(wlast), 64'(beat == BLEN-1));
                if (!first_wd_ok) begin first_wd = wdata; first_wd_ok = 1; end
                if (wlast) wlast_cnt++;
                beats_total++;
                beat++;
            end
            if (bvalid && bready) begin
                m_bcnt++;
                if (bresp != 2'b00 && m_err < 16'hFFFF) m_err++;
                m_acnt = (m_acnt + 1 >= int'(size)) ? 0 : m_acnt + 1;
                nb_hs++;
            end
            if (idle && syncing) begin
                mq.delete();
                m_acnt = 0; m_bcnt = 0; m_pend = 0;
                exp_launch = 0;
            end else begin
                if (sync) m_pend = 1;
                if (idle) begin
                    exp_launch = (level >= BLEN && size != 0) ? 1 : 0;
                    if (exp_launch == 1) exp_addr = base + 32'(m_acnt) * 32'd64;
                end
                if (Ien && !syncing) begin
                    if (level < DEPTH) mq.push_back(Sin);
                    else if (m_ovf < 16'hFFFF) m_ovf++;
                end
            end
        end
    end

    // slave-side handshake driver
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 6'h3F;
        forever begin
            @(posedge clk); #1;
            awready = (aw_mode == 2) ? ($urandom % 2 == 1) : (aw_mode == 1);
            wready  = (w_mode == 2)  ? ($urandom % 2 == 1) : (w_mode == 1);
            bvalid  = bready && (b_rand != 0 ? ($urandom % 2 == 1) : 1'b1);
            bresp   = (nb_hs == err_at) ? 2'b10 : 2'b00;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0; Ien = 0; sync = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        aw_log.delete(); wlast_cnt = 0; beats_total = 0; first_wd_ok = 0; nb_hs = 0;
    endtask

    task automatic push_words(int n, logic [31:0] first, bit sync_on_w);
        bit done = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            Ien = 1;
            Sin = (i == 0) ? first : $urandom;
            sync = sync_on_w && wvalid && !done;
            if (sync) done = 1;
        end
        @(posedge clk); #1;
        Ien = 0; sync = 0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (!(mq.size() < BLEN && !awvalid && !wvalid && !bready && m_pend == 0) && n < 4000) begin
            @(negedge clk); n++;
        end
        if (n >= 4000) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 0; sync = 0; Ien = 0; Sin = 0; base = 32'h1000_0000; size = 18'd4;
        first_wd_ok = 0;

        // 1: continuous stream, ring of 4 bursts wraps once
        do_reset();
        @(negedge clk);
        chk("reset_acnt", 64'(acnt), 64'd0);
        chk("reset_awvalid", 64'(awvalid), 64'd0);
        chk("reset_awaddr", 64'(awaddr), 64'd0);
        push_words(80, 32'h1122_3344, 0);
        drain("s1");
        chk("s1_bursts", 64'(aw_log.size()), 64'd5);
        if (aw_log.size() == 5) begin
            chk("s1_addr0", 64'(aw_log[0]), 64'h1000_0000);
            chk("s1_addr1", 64'(aw_log[1]), 64'h1000_0040);
            chk("s1_addr2", 64'(aw_log[2]), 64'h1000_0080);
            chk("s1_addr3", 64'(aw_log[3]), 64'h1000_00C0);
            chk("s1_addr4", 64'(aw_log[4]), 64'h1000_0000);
        end
        chk("s1_acnt", 64'(acnt), 64'd1);
        chk("s1_bcnt", 64'(bcnt), 64'd5);
        chk("s1_wlast", 64'(wlast_cnt), 64'd5);
`ifdef AXI_S2MM_BSWAP_EN
        chk("s1_first_wdata", 64'(first_wd), 64'h4433_2211);
`else
        chk("s1_first_wdata", 64'(first_wd), 64'h1122_3344);
`endif
        chk("awlen", 64'(awlen), 64'd15);
        chk("awsize", 64'(awsize), 64'd2);

        // 2: random stalls on all channels
        do_reset();
        aw_mode = 2; w_mode = 2; b_rand = 1; size = 18'd8; base = 32'h2000_0000;
        push_words(32, 32'hA5A5_0001, 0);
        drain("s2");
        chk("s2_beats", 64'(beats_total), 64'd32);
        chk("s2_wlast", 64'(wlast_cnt), 64'd2);
        chk("s2_bcnt", 64'(bcnt), 64'd2);

        // 3: wready held low, FIFO overflows
        do_reset();
        aw_mode = 1; w_mode = 0; b_rand = 0; size = 18'd4;
        push_words(40, 32'h0000_0001, 0);
        @(negedge clk);
        chk("s3_ovf", 64'(ovf_cnt), 64'd8);
        w_mode = 2;
        drain("s3");
        chk("s3_bcnt", 64'(bcnt), 64'd2);
        chk("s3_beats", 64'(beats_total), 64'd32);

        // 4: error response on the second burst
        do_reset();
        aw_mode = 2; w_mode = 1; b_rand = 1; err_at = 1;
        push_words(32, $urandom, 0);
        drain("s4");
        chk("s4_err", 64'(err_cnt), 64'd1);
        chk("s4_bcnt", 64'(bcnt), 64'd2);
        chk("s4_acnt", 64'(acnt), 64'd2);
        err_at = -1;

        // 5: sync during the first burst's data phase
        do_reset();
        aw_mode = 1; w_mode = 1; b_rand = 0; base = 32'h3000_0000;
        push_words(30, $urandom, 1);
        drain("s5");
        chk("s5_acnt", 64'(acnt), 64'd0);
        chk("s5_bcnt", 64'(bcnt), 64'd0);
        chk("s5_burst0", 64'(aw_log.size()), 64'd1);
        aw_log.delete();
        push_words(16, $urandom, 0);
        drain("s5b");
        chk("s5_relaunch", 64'(aw_log.size()), 64'd1);
        if (aw_log.size() > 0) chk("s5_addr", 64'(aw_log[0]), 64'h3000_0000);
        chk("s5_bcnt_after", 64'(bcnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
